// File: rtl/fibo_seq_engine_if.sv
// fibo_seq_engine_if: command, term-stream and status signals of the Fibonacci engine
interface fibo_seq_engine_if #(
   parameter int WIDTH = 8,
   parameter int CNT_W = 5
);
   logic             start;
   logic [CNT_W-1:0] count;
   logic             out_ready;
   logic             term_valid;
   logic [WIDTH-1:0] data_out;
   logic [CNT_W-1:0] term_idx;
   logic             zero_flag;
   logic             overflow;
   logic             busy;
   logic             done;
   modport master (
      output start, count, out_ready,
      input  term_valid, data_out, term_idx, zero_flag, overflow, busy, done
   );
   modport slave (
      input  start, count, out_ready,
      output term_valid, data_out, term_idx, zero_flag, overflow, busy, done
   );
endinterface

// File: rtl/fibo_seq_engine.sv
// fibo_seq_engine: streams F(0)..F(N) over valid/ready with overflow detection.
// Define FIBO_SAT_EN to saturate terms at 2^WIDTH-1 instead of wrapping.
module fibo_seq_engine #(
   parameter int WIDTH = 8,
   parameter int CNT_W = 5
) (
   input logic Clk,
   input logic Rst,
   fibo_seq_engine_if.slave bus
);
   typedef enum logic [1:0] {IDLE, INIT, EMIT, DONE} state_t;
   state_t           state;
   logic [WIDTH-1:0] a, b, nxt;
   logic [WIDTH:0]   sum;
   logic             b_ovf, xfer;
   logic [CNT_W-1:0] idx, n;
   assign sum  = {1'b0, a} + {1'b0, b};
   assign xfer = bus.term_valid && bus.out_ready;
`ifdef FIBO_SAT_EN
   assign nxt = sum[WIDTH] ? '1 : sum[WIDTH-1:0];
`else
   assign nxt = sum[WIDTH-1:0];
`endif
   // b_ovf stays set once b's true value has left the WIDTH range, even after wrapping
   always_ff @(posedge Clk) begin
      if (Rst) begin
         state          <= IDLE;
         a              <= '0;
         b              <= '0;
         b_ovf          <= 1'b0;
         idx            <= '0;
         n              <= '0;
         bus.term_valid <= 1'b0;
         bus.data_out   <= '0;
         bus.term_idx   <= '0;
         bus.zero_flag  <= 1'b1;
         bus.overflow   <= 1'b0;
         bus.busy       <= 1'b0;
         bus.done       <= 1'b0;
      end else begin
         bus.done <= 1'b0;
         case (state)
            IDLE: if (bus.start) begin
               n            <= bus.count;
               bus.overflow <= 1'b0;
               bus.busy     <= 1'b1;
               state        <= INIT;
            end
            INIT: begin
               a              <= '0;
               b              <= WIDTH'(1);
               b_ovf          <= 1'b0;
               idx            <= '0;
               bus.data_out   <= '0;
               bus.term_idx   <= '0;
               bus.zero_flag  <= 1'b1;
               bus.term_valid <= 1'b1;
               state          <= EMIT;
            end
            EMIT: if (xfer) begin
               if (bus.term_idx == n) begin
                  bus.term_valid <= 1'b0;
                  bus.busy       <= 1'b0;
                  bus.done       <= 1'b1;
                  state          <= DONE;
               end else begin
                  bus.data_out  <= b;
                  bus.zero_flag <= (b == '0);
                  bus.term_idx  <= idx + 1'b1;
                  bus.overflow  <= bus.overflow | b_ovf;
                  a             <= b;
                  b             <= nxt;
                  b_ovf         <= b_ovf | sum[WIDTH];
                  idx           <= idx + 1'b1;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_fibo_seq_engine.sv
// tb_fibo_seq_engine: directed runs checked every cycle against an arithmetic Fibonacci model
module tb_fibo_seq_engine;
   localparam int W = 8;
   localparam int C = 5;
   logic Clk = 1'b0;
   logic Rst = 1'b1;
   fibo_seq_engine_if #(.WIDTH(W), .CNT_W(C)) bus ();
   fibo_seq_engine #(.WIDTH(W), .CNT_W(C)) dut (.Clk(Clk), .Rst(Rst), .bus(bus));
   always #5 Clk = ~Clk;

   int checks = 0;
   int errors = 0;
   int exp_idx = 0;
   int xfers = 0;
   int stalls = 0;
   bit mon = 1'b0;
   logic [W-1:0] got [0:31];

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   function automatic longint fib(input int k);
      longint x = 0, y = 1, t;
      for (int i = 0; i < k; i++) begin
         t = x + y;
         x = y;
         y = t;
      end
      return x;
   endfunction

   function automatic longint exp_term(input int k);
      longint f = fib(k);
`ifdef FIBO_SAT_EN
      return (f >= (64'd1 << W)) ? (64'd1 << W) - 1 : f;
`else
      return f % (64'd1 << W);
`endif
   endfunction

   function automatic bit exp_ovf(input int k);
      return fib(k) >= (64'd1 << W);
   endfunction

   // one compare point per cycle the output holds a term; a stall re-checks the same term
   always @(negedge Clk) begin
      if (mon && !Rst && bus.term_valid) begin
         chk("term_idx", 64'(bus.term_idx), 64'(exp_idx));
         chk("data_out", 64'(bus.data_out), 64'(exp_term(exp_idx)));
         chk("zero_flag", 64'(bus.zero_flag), 64'(exp_term(exp_idx) == 0));
         chk("overflow", 64'(bus.overflow), 64'(exp_ovf(exp_idx)));
         chk("busy_valid", 64'(bus.busy), 64'd1);
         if (bus.out_ready) begin
            if (exp_idx < 32) got[exp_idx] = bus.data_out;
            exp_idx++;
            xfers++;
         end else stalls++;
      end
   end

   task automatic run(input int n, input bit toggle, input int pulse_at);
      logic [3:0] pat = 4'b1001;
      int e = 0;
      int k = 0;
      int done_at = -1;
      int busy_cyc;
      exp_idx = 0;
      xfers = 0;
      stalls = 0;
      mon = 1'b1;
      bus.start = 1'b1;
      bus.count = C'(n);
      bus.out_ready = 1'b1;
      @(posedge Clk);
      #1;
      bus.start = 1'b0;
      bus.count = C'(n + 7);
      busy_cyc = int'(bus.busy);
      while (e < 200 && done_at < 0) begin
         bus.out_ready = toggle ? pat[k % 4] : 1'b1;
         bus.start = (pulse_at >= 0 && bus.term_valid && int'(bus.term_idx) == pulse_at);
         k++;
         @(posedge Clk);
         e++;
         #1;
         if (bus.busy) busy_cyc++;
         if (bus.done) done_at = e;
      end
      bus.start = 1'b0;
      mon = 1'b0;
      chk("done_edge", 64'(done_at), 64'(n + 2 + stalls));
      chk("term_count", 64'(xfers), 64'(n + 1));
      chk("busy_cycles", 64'(busy_cyc), 64'(n + 2 + stalls));
      chk("valid_after_done", 64'(bus.term_valid), 64'd0);
      chk("retain_idx", 64'(bus.term_idx), 64'(n));
      chk("retain_data", 64'(bus.data_out), 64'(exp_term(n)));
      @(posedge Clk);
      #1;
      chk("done_pulse_width", 64'(bus.done), 64'd0);
   endtask

   initial begin
      bus.start = 1'b0;
      bus.count = '0;
      bus.out_ready = 1'b0;
      repeat (2) @(posedge Clk);
      #1;
      chk("rst_busy", 64'(bus.busy), 64'd0);
      chk("rst_done", 64'(bus.done), 64'd0);
      chk("rst_valid", 64'(bus.term_valid), 64'd0);
      chk("rst_data", 64'(bus.data_out), 64'd0);
      chk("rst_idx", 64'(bus.term_idx), 64'd0);
      chk("rst_ovf", 64'(bus.overflow), 64'd0);
      chk("rst_zero", 64'(bus.zero_flag), 64'd1);
      Rst = 1'b0;
      @(posedge Clk);
      #1;
      run(10, 1'b0, -1);
      chk("f10_lit", 64'(got[10]), 64'd55);
      chk("f7_lit", 64'(got[7]), 64'd13);
      chk("ovf_n10", 64'(bus.overflow), 64'd0);
      run(0, 1'b0, -1);
      chk("f0_lit", 64'(got[0]), 64'd0);
      run(15, 1'b0, -1);
      chk("f13_lit", 64'(got[13]), 64'd233);
`ifdef FIBO_SAT_EN
      chk("f14_lit", 64'(got[14]), 64'd255);
      chk("f15_lit", 64'(got[15]), 64'd255);
`else
      chk("f14_lit", 64'(got[14]), 64'd121);
      chk("f15_lit", 64'(got[15]), 64'd98);
`endif
      chk("ovf_sticky", 64'(bus.overflow), 64'd1);
      run(5, 1'b1, -1);
      chk("stall_f5_lit", 64'(got[5]), 64'd5);
      chk("stall_seen", 64'(stalls > 0), 64'd1);
      run(6, 1'b0, 3);
      chk("pulse_f6_lit", 64'(got[6]), 64'd8);
      exp_idx = 0;
      mon = 1'b1;
      bus.start = 1'b1;
      bus.count = C'(8);
      bus.out_ready = 1'b1;
      @(posedge Clk);
      #1;
      bus.start = 1'b0;
      for (int i = 0; i < 20; i++) begin
         if (bus.term_valid && bus.term_idx == C'(4)) break;
         @(posedge Clk);
         #1;
      end
      chk("reach_term4", 64'(bus.term_idx), 64'd4);
      Rst = 1'b1;
      @(posedge Clk);
      #1;
      Rst = 1'b0;
      mon = 1'b0;
      chk("mid_rst_busy", 64'(bus.busy), 64'd0);
      chk("mid_rst_valid", 64'(bus.term_valid), 64'd0);
      chk("mid_rst_data", 64'(bus.data_out), 64'd0);
      chk("mid_rst_idx", 64'(bus.term_idx), 64'd0);
      chk("mid_rst_zero", 64'(bus.zero_flag), 64'd1);
      chk("mid_rst_done", 64'(bus.done), 64'd0);
      chk("mid_rst_ovf", 64'(bus.overflow), 64'd0);
      @(posedge Clk);
      #1;
      chk("idle_no_busy", 64'(bus.busy), 64'd0);
      run(2, 1'b0, -1);
      chk("post_rst_f1_lit", 64'(got[1]), 64'd1);
      chk("post_rst_f2_lit", 64'(got[2]), 64'd1);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
